// File: rtl/axis_level_trigger.sv
// Level trigger on an AXI-Stream pass-through: hysteresis-qualified crossing
// detector with arm/disarm control, optional auto re-arm after a beat holdoff.
module axis_level_trigger #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH     = 14,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic [SAMPLE_WIDTH-1:0]       cfg_level,
    input  logic [SAMPLE_WIDTH-2:0]       cfg_hyst,
    input  logic [1:0]                    cfg_mode,
    input  logic                          cfg_auto,
    input  logic [CNTR_WIDTH-1:0]         cfg_holdoff,
    input  logic                          arm,
    input  logic                          disarm,
    output logic                          trg_out,
    output logic                          state_out,
    output logic                          armed_out,
    output logic [CNTR_WIDTH-1:0]         trg_count,
    output logic [CNTR_WIDTH-1:0]         trg_pos
);

    localparam int TW = SAMPLE_WIDTH + 1;
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HOLDOFF
    } state_t;

    typedef enum logic [1:0] {
        RG_UNKNOWN,
        RG_LOW,
        RG_HIGH
    } region_t;

    state_t                  state_q, state_d;
    region_t                 region_q, region_d;
    logic [CNTR_WIDTH-1:0]   idx_q, idx_d;
    logic [CNTR_WIDTH-1:0]   hold_q, hold_d;
    logic [CNTR_WIDTH-1:0]   count_q, count_d;
    logic [CNTR_WIDTH-1:0]   pos_q, pos_d;
    logic                    trg_q, trg_d;
    logic                    sticky_q, sticky_d;

    logic                    beat;
    logic signed [TW-1:0]    sample_x;
    logic signed [TW-1:0]    level_x;
    logic signed [TW-1:0]    hyst_x;
    logic signed [TW-1:0]    thr_lo;
    logic signed [TW-1:0]    thr_hh;
    logic                    below_lo;
    logic                    at_or_above_hi;
    logic                    above_hh;
    logic                    rise;
    logic                    fall;
    logic                    qualified;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = s_axis_tvalid;
    assign s_axis_tready = m_axis_tready;

    assign beat = s_axis_tvalid & m_axis_tready;

    // One extra bit keeps level-hyst and level+hyst from wrapping at the rails.
    assign sample_x = {s_axis_tdata[SAMPLE_WIDTH-1], s_axis_tdata[SAMPLE_WIDTH-1:0]};
    assign level_x  = {cfg_level[SAMPLE_WIDTH-1], cfg_level};
    assign hyst_x   = {2'b00, cfg_hyst};
    assign thr_lo   = level_x - hyst_x;
    assign thr_hh   = level_x + hyst_x;

    assign below_lo       = sample_x < thr_lo;
    assign at_or_above_hi = sample_x >= level_x;
    assign above_hh       = sample_x >= thr_hh;

    assign rise = (region_q == RG_LOW)  &&  at_or_above_hi;
    assign fall = (region_q == RG_HIGH) && !at_or_above_hi;

    always_comb begin
        qualified = 1'b0;
        case (cfg_mode)
            2'b00:   qualified = rise;
            2'b01:   qualified = fall;
            2'b10:   qualified = rise | fall;
            default: qualified = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        count_d  = count_q;
        pos_d    = pos_q;
        trg_d    = 1'b0;
        sticky_d = sticky_q;

        if (beat) begin
            idx_d = idx_q + CNT_ONE;
            if (below_lo) begin
                region_d = RG_LOW;
            end else if (above_hh) begin
                region_d = RG_HIGH;
            end
        end

        if (disarm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d  = ST_ARMED;
                        sticky_d = 1'b0;
                        region_d = RG_UNKNOWN;
                    end
                end
                ST_ARMED: begin
                    if (beat && qualified) begin
                        trg_d    = 1'b1;
                        sticky_d = 1'b1;
                        count_d  = count_q + CNT_ONE;
                        pos_d    = idx_q;
                        if (!cfg_auto) begin
                            state_d = ST_IDLE;
                        end else if (cfg_holdoff == '0) begin
                            state_d  = ST_ARMED;
                            region_d = RG_UNKNOWN;
                        end else begin
                            state_d = ST_HOLDOFF;
                            hold_d  = cfg_holdoff;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (arm) begin
                        state_d  = ST_ARMED;
                        sticky_d = 1'b0;
                        region_d = RG_UNKNOWN;
                    end else if (beat) begin
                        hold_d = hold_q - CNT_ONE;
                        if (hold_q <= CNT_ONE) begin
                            hold_d   = '0;
                            state_d  = ST_ARMED;
                            region_d = RG_UNKNOWN;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            region_q <= RG_UNKNOWN;
            idx_q    <= '0;
            hold_q   <= '0;
            count_q  <= '0;
            pos_q    <= '0;
            trg_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            count_q  <= count_d;
            pos_q    <= pos_d;
            trg_q    <= trg_d;
            sticky_q <= sticky_d;
        end
    end

    assign trg_out   = trg_q;
    assign state_out = sticky_q;
    assign armed_out = (state_q == ST_ARMED);
    assign trg_count = count_q;
    assign trg_pos   = pos_q;

endmodule

// File: tb/tb_axis_level_trigger.sv
// Self-checking bench for axis_level_trigger: vector table plus directed
// sequences; expected trigger records queue up and are matched on trg_out.
module tb_axis_level_trigger;

    localparam int DW = 32;
    localparam int SW = 14;
    localparam int CW = 32;

    logic              aclk;
    logic              areset;
    logic [DW-1:0]     s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [SW-1:0]     cfg_level;
    logic [SW-2:0]     cfg_hyst;
    logic [1:0]        cfg_mode;
    logic              cfg_auto;
    logic [CW-1:0]     cfg_holdoff;
    logic              arm;
    logic              disarm;
    logic              trg_out;
    logic              state_out;
    logic              armed_out;
    logic [CW-1:0]     trg_count;
    logic [CW-1:0]     trg_pos;

    axis_level_trigger #(
        .AXIS_TDATA_WIDTH(DW),
        .SAMPLE_WIDTH(SW),
        .CNTR_WIDTH(CW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .cfg_level(cfg_level),
        .cfg_hyst(cfg_hyst),
        .cfg_mode(cfg_mode),
        .cfg_auto(cfg_auto),
        .cfg_holdoff(cfg_holdoff),
        .arm(arm),
        .disarm(disarm),
        .trg_out(trg_out),
        .state_out(state_out),
        .armed_out(armed_out),
        .trg_count(trg_count),
        .trg_pos(trg_pos)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        bit        do_arm;
        bit [1:0]  mode;
        int        sample;
        bit        trig;
    } vec_t;

    typedef struct {
        logic [CW-1:0] count;
        logic [CW-1:0] pos;
    } exp_t;

    exp_t          sbq[$];
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] exp_idx = '0;
    logic [CW-1:0] exp_count = '0;
    vec_t          vt[21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    always @(negedge aclk) begin : monitor
        exp_t e;
        if (!areset && trg_out) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_trigger: trg_out=1 trg_pos=%0d, expected no trigger", trg_pos);
            end else begin
                e = sbq.pop_front();
                check("trg_count", trg_count, e.count);
                check("trg_pos", trg_pos, e.pos);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
    endtask

    task automatic beat(input int s, input bit trig);
        exp_t e;
        s_axis_tdata  = s;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        if (trig) begin
            exp_count = exp_count + 1;
            e.count   = exp_count;
            e.pos     = exp_idx;
            sbq.push_back(e);
        end
        exp_idx = exp_idx + 1;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        // level 100, hyst 10: lo=90, hi=100, high region from 110
        vt = '{
            '{1, 2'b00,   0, 0}, '{0, 2'b00,  50, 0}, '{0, 2'b00,  95, 0},
            '{0, 2'b00, 120, 1}, '{1, 2'b00,  95, 0}, '{0, 2'b00, 101, 0},
            '{0, 2'b00,  95, 0}, '{0, 2'b00, 101, 0}, '{0, 2'b00,  80, 0},
            '{0, 2'b00, 100, 1}, '{1, 2'b01, 150, 0}, '{0, 2'b01, 105, 0},
            '{0, 2'b01,  99, 1}, '{1, 2'b10,  20, 0}, '{0, 2'b10, 130, 1},
            '{1, 2'b10, 130, 0}, '{0, 2'b10,  40, 1}, '{1, 2'b11,  20, 0},
            '{0, 2'b11, 130, 0}, '{0, 2'b11,  20, 0}, '{0, 2'b00, 130, 1}
        };

        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cfg_level     = 14'd100;
        cfg_hyst      = 13'd10;
        cfg_mode      = 2'b00;
        cfg_auto      = 1'b0;
        cfg_holdoff   = '0;
        arm           = 1'b0;
        disarm        = 1'b0;
        repeat (3) tick();
        check("rst_trg_out", trg_out, 0);
        check("rst_state_out", state_out, 0);
        check("rst_armed_out", armed_out, 0);
        check("rst_trg_count", trg_count, 0);
        check("rst_trg_pos", trg_pos, 0);
        areset = 1'b0;
        tick();

        for (int i = 0; i < 21; i++) begin
            cfg_mode = vt[i].mode;
            if (vt[i].do_arm) begin
                pulse_arm();
                check("armed_after_arm", armed_out, 1);
                check("state_cleared_by_arm", state_out, 0);
            end
            beat(vt[i].sample, vt[i].trig);
        end
        tick();
        check("idle_after_trigger", armed_out, 0);
        check("state_sticky", state_out, 1);

        // backpressure: crossing sample presented but not accepted
        cfg_mode = 2'b00;
        pulse_arm();
        beat(0, 0);
        s_axis_tdata  = 32'd120;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b0;
        repeat (3) begin
            tick();
            check("bp_tready", s_axis_tready, 0);
            check("bp_armed", armed_out, 1);
        end
        check("bp_tvalid_pass", m_axis_tvalid, 1);
        check("bp_tdata_pass", m_axis_tdata, 32'd120);
        beat(120, 1);

        // arm and disarm together, then disarm racing a trigger
        arm    = 1'b1;
        disarm = 1'b1;
        tick();
        arm    = 1'b0;
        disarm = 1'b0;
        check("arm_disarm_idle", armed_out, 0);
        beat(0, 0);
        beat(120, 0);
        pulse_arm();
        beat(0, 0);
        disarm = 1'b1;
        beat(120, 0);
        disarm = 1'b0;
        check("disarm_wins_idle", armed_out, 0);
        check("disarm_wins_state", state_out, 0);

        // level at negative rail: lo must not wrap
        cfg_level = 14'h2000;
        cfg_hyst  = 13'd100;
        cfg_mode  = 2'b10;
        pulse_arm();
        beat(-8192, 0);
        beat(8191, 0);
        beat(-8192, 0);
        beat(8191, 0);
        check("neg_rail_still_armed", armed_out, 1);

        // auto re-arm with holdoff 3 on a +/-50 square wave
        pulse_disarm();
        cfg_level   = 14'd0;
        cfg_hyst    = 13'd5;
        cfg_mode    = 2'b00;
        cfg_auto    = 1'b1;
        cfg_holdoff = 32'd3;
        pulse_arm();
        for (int i = 0; i < 14; i++) begin
            beat((i % 2 == 0) ? -50 : 50, (i % 6) == 1);
            check("auto_armed", armed_out, ((i % 6) == 0 || (i % 6) >= 4) ? 1 : 0);
        end
        check("auto_state", state_out, 1);

        pulse_disarm();
        cfg_holdoff = '0;
        pulse_arm();
        beat(-50, 0);
        beat(50, 1);
        check("holdoff0_rearmed", armed_out, 1);

        // asynchronous reset while in holdoff
        pulse_disarm();
        cfg_holdoff = 32'd3;
        pulse_arm();
        beat(-50, 0);
        beat(50, 1);
        beat(-50, 0);
        check("in_holdoff", armed_out, 0);
        s_axis_tdata  = 32'h1234_5678;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        check("arst_trg_out", trg_out, 0);
        check("arst_state_out", state_out, 0);
        check("arst_armed_out", armed_out, 0);
        check("arst_trg_count", trg_count, 0);
        check("arst_trg_pos", trg_pos, 0);
        check("arst_tdata_pass", m_axis_tdata, 32'h1234_5678);
        check("arst_tvalid_pass", m_axis_tvalid, 1);
        tick();
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        exp_idx       = '0;
        exp_count     = '0;
        pulse_arm();
        beat(-50, 0);
        beat(50, 1);

        repeat (3) tick();
        check("pending_triggers", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_level_trigger.md
AXIS_LEVEL_TRIGGER -- requirements
Module: axis_level_trigger

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, stream data width.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 14, width of signed sample in tdata[SAMPLE_WIDTH-1:0].
REQ-003 SHALL have parameter CNTR_WIDTH, default 32, width of holdoff, sample-index and trigger counters.
REQ-004 SHALL have port aclk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port areset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port s_axis_tdata  input  AXIS_TDATA_WIDTH  input samples.
REQ-007 SHALL have port s_axis_tvalid  input  1; s_axis_tready  output  1.
REQ-008 SHALL have port m_axis_tdata  output  AXIS_TDATA_WIDTH; m_axis_tvalid  output  1; m_axis_tready  input  1.
REQ-009 SHALL have port cfg_level  input  SAMPLE_WIDTH  signed trigger level.
REQ-010 SHALL have port cfg_hyst  input  SAMPLE_WIDTH-1  unsigned hysteresis.
REQ-011 SHALL have port cfg_mode  input  2  00 rising, 01 falling, 10 either, 11 disabled.
REQ-012 SHALL have port cfg_auto  input  1  1 = auto re-arm after holdoff.
REQ-013 SHALL have port cfg_holdoff  input  CNTR_WIDTH  holdoff length in accepted beats.
REQ-014 SHALL have ports arm, disarm  input  1 each  single-cycle control pulses.
REQ-015 SHALL have port trg_out  output  1  one-cycle trigger pulse.
REQ-016 SHALL have port state_out  output  1  sticky "triggered since last arm".
REQ-017 SHALL have port armed_out  output  1  high in ARMED state.
REQ-018 SHALL have port trg_count  output  CNTR_WIDTH  triggers since reset.
REQ-019 SHALL have port trg_pos  output  CNTR_WIDTH  sample index of last trigger beat.

Function
REQ-020 SHALL pass stream through combinationally: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
REQ-021 SHALL define beat = cycle with s_axis_tvalid & m_axis_tready; only beats update detector, counters, holdoff.
REQ-022 SHALL keep sample index: +1 per beat, wraps modulo 2^CNTR_WIDTH; value of beat k is k (first beat after reset = 0).
REQ-023 SHALL compute thresholds in SAMPLE_WIDTH+1 signed bits: hi=level, lo=level-hyst (no wrap).
REQ-024 SHALL track region per beat: sample<lo -> LOW; sample>=hi+hyst -> HIGH; otherwise region unchanged; region UNKNOWN after arm or holdoff expiry.
REQ-025 SHALL detect rising crossing: region LOW and sample>=hi; falling: region HIGH and sample<hi; UNKNOWN never crosses.
REQ-026 SHALL qualify crossing by cfg_mode; mode 11 never triggers.
REQ-027 SHALL use FSM IDLE, ARMED, HOLDOFF; IDLE after reset.
REQ-028 SHALL on arm in IDLE or HOLDOFF: go ARMED, clear state_out, region UNKNOWN; arm in ARMED: ignored.
REQ-029 SHALL on disarm: go IDLE from any state; disarm wins over simultaneous arm or trigger.
REQ-030 SHALL on qualified crossing in ARMED: next cycle trg_out=1 for exactly one cycle, state_out=1, trg_count+1 (wraps), trg_pos=beat index.
REQ-031 SHALL after trigger go IDLE if cfg_auto=0; if cfg_auto=1 go HOLDOFF with counter=cfg_holdoff, or directly ARMED (region UNKNOWN) if cfg_holdoff=0.
REQ-032 SHALL in HOLDOFF decrement counter per beat, ignore crossings, enter ARMED (region UNKNOWN) on beat that brings counter to 0.
REQ-033 SHALL sample cfg_* per beat; changes mid-stream take effect on next beat.

Reset
REQ-034 SHALL on areset asynchronously force IDLE, region UNKNOWN, trg_out=0, state_out=0, armed_out=0, trg_count=0, trg_pos=0, sample index=0, holdoff counter=0.
REQ-035 SHALL pass-through outputs unaffected by areset.

Verification
REQ-036 Rising: level=100, hyst=10, mode=00, arm; beats 0,50,95,120 -> trg_out one cycle after beat 3, trg_pos=3, trg_count=1, FSM IDLE.
REQ-037 Hysteresis: level=100, hyst=10, rising; beats 95,101,95,101 -> no trigger; then 80,100 -> trigger on 100.
REQ-038 Auto: cfg_auto=1, holdoff=3, square wave -50/+50, level=0, hyst=5 -> triggers spaced by holdoff + re-qualification, trg_count increments each.
REQ-039 Backpressure: m_axis_tready=0 with crossing sample on tdata -> no trigger, no index advance until accepted.
REQ-040 Arm+disarm same cycle -> IDLE; crossing then -> no trigger; areset mid-HOLDOFF -> all outputs REQ-034 values.
REQ-041 Negative/edge: level=-8192, SAMPLE_WIDTH=14, hyst=100 -> lo computed without wrap, no false trigger on sample 8191.
